// File: rtl/pulse_mode_counter_if.sv
// Mode inputs, parallel load and registered counter outputs of pulse_mode_counter.
// The master drives the mode and load inputs; the slave (the counter) drives the count and flags.
interface pulse_mode_counter_if #(
    parameter int WIDTH = 16
);
    logic             inc;
    logic             dec;
    logic             inc2;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             incf;
    logic             decf;
    logic             zf;
    logic             ovf;

    modport master (
        output inc, dec, inc2, load, load_val,
        input  count, incf, decf, zf, ovf
    );

    modport slave (
        input  inc, dec, inc2, load, load_val,
        output count, incf, decf, zf, ovf
    );
endinterface

// File: rtl/pulse_mode_counter.sv
// Multi-mode up/up-by-STEP2/down counter fed by synchronised switch levels.
// Latency: SYNC_STAGES+1 edges from raw capture to first step, load in one edge; no backpressure.
module pulse_mode_counter #(
    parameter int WIDTH       = 16,
    parameter int STEP2       = 2,
    parameter int SATURATE    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    pulse_mode_counter_if.slave  bus
);
    localparam bit SAT = (SATURATE != 0);
    localparam logic [WIDTH:0] STEP2_X = (WIDTH+1)'(STEP2);

    typedef enum logic [4:0] {
        RESET = 5'b00001,
        IDLE  = 5'b00010,
        INC   = 5'b00100,
        INC2  = 5'b01000,
        DEC   = 5'b10000
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] inc_sync;
    logic [SYNC_STAGES-1:0] dec_sync;
    logic [SYNC_STAGES-1:0] inc2_sync;
    logic                   s_inc;
    logic                   s_dec;
    logic                   s_inc2;

    logic [WIDTH-1:0] count_q;
    logic             incf_q;
    logic             decf_q;
    logic             zf_q;
    logic             ovf_q;

    // Shift the raw level in at bit 0; the top bit is the synchronised copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_sync  <= '0;
            dec_sync  <= '0;
            inc2_sync <= '0;
        end else begin
            inc_sync  <= SYNC_STAGES'({inc_sync,  bus.inc});
            dec_sync  <= SYNC_STAGES'({dec_sync,  bus.dec});
            inc2_sync <= SYNC_STAGES'({inc2_sync, bus.inc2});
        end
    end

    assign s_inc  = inc_sync[SYNC_STAGES-1];
    assign s_dec  = dec_sync[SYNC_STAGES-1];
    assign s_inc2 = inc2_sync[SYNC_STAGES-1];

    logic [WIDTH:0]   up1_x;
    logic [WIDTH:0]   up2_x;
    logic [WIDTH-1:0] up1_val;
    logic [WIDTH-1:0] up2_val;
    logic             dn_borrow;
    logic [WIDTH-1:0] dn_val;

    // The extra top bit of the up sums is the carry out, i.e. the overflow condition.
    assign up1_x     = {1'b0, count_q} + (WIDTH+1)'(1);
    assign up2_x     = {1'b0, count_q} + STEP2_X;
    assign up1_val   = (SAT && up1_x[WIDTH]) ? {WIDTH{1'b1}} : up1_x[WIDTH-1:0];
    assign up2_val   = (SAT && up2_x[WIDTH]) ? {WIDTH{1'b1}} : up2_x[WIDTH-1:0];
    assign dn_borrow = (count_q == '0);
    assign dn_val    = (SAT && dn_borrow) ? '0 : count_q - WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RESET;
            count_q <= '0;
            incf_q  <= 1'b0;
            decf_q  <= 1'b0;
            zf_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            incf_q <= 1'b0;
            decf_q <= 1'b0;
            ovf_q  <= 1'b0;
            if (!(state inside {IDLE, INC, INC2, DEC})) begin
                state <= (state == RESET) ? IDLE : RESET;
            end else if (bus.load) begin
                count_q <= bus.load_val;
                zf_q    <= (bus.load_val == '0);
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (s_inc)       state <= INC;
                        else if (s_dec)  state <= DEC;
                        else if (s_inc2) state <= INC2;
                    end
                    INC: begin
                        if (s_inc) begin
                            count_q <= up1_val;
                            zf_q    <= (up1_val == '0);
                            incf_q  <= 1'b1;
                            ovf_q   <= up1_x[WIDTH];
                        end else begin
                            state <= IDLE;
                        end
                    end
                    INC2: begin
                        if (s_inc2) begin
                            count_q <= up2_val;
                            zf_q    <= (up2_val == '0);
                            incf_q  <= 1'b1;
                            ovf_q   <= up2_x[WIDTH];
                        end else begin
                            state <= IDLE;
                        end
                    end
                    DEC: begin
                        if (s_dec) begin
                            count_q <= dn_val;
                            zf_q    <= (dn_val == '0);
                            decf_q  <= 1'b1;
                            ovf_q   <= dn_borrow;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= RESET;
                endcase
            end
        end
    end

    assign bus.count = count_q;
    assign bus.incf  = incf_q;
    assign bus.decf  = decf_q;
    assign bus.zf    = zf_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: doc/pulse_mode_counter.md
# pulse_mode_counter

Parametrised multi-mode pulse counter for the switch-driven counter datapath. It counts up by 1, up by STEP2, or down by 1 while the corresponding mode input is held, with registered increment, decrement, zero and overflow flags. Compared with the first-generation counter it adds:
- a configurable counter width and second step size;
- input synchronisers for asynchronous slide-switch inputs;
- selectable wrap or saturate arithmetic;
- a synchronous parallel load.

## Interface
Parameters:
- WIDTH, 16, counter width in bits (>= 2)
- STEP2, 2, step applied in INC2 mode (1 .. 2^WIDTH-1)
- SATURATE, 0, 0 = modulo-2^WIDTH wrap; 1 = clamp at 0 and 2^WIDTH-1
- SYNC_STAGES, 2, flip-flop stages on each of inc, dec, inc2 (>= 1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- inc  in  1  level, asynchronous; count up by 1 while high
- dec  in  1  level, asynchronous; count down by 1 while high
- inc2  in  1  level, asynchronous; count up by STEP2 while high
- load  in  1  synchronous; load load_val into the counter
- load_val  in  WIDTH  value loaded when load=1
- count  out  WIDTH  registered counter value
- incf  out  1  registered; high while counting in INC or INC2
- decf  out  1  registered; high while counting in DEC
- zf  out  1  registered; high iff count == 0
- ovf  out  1  registered one-cycle pulse on wrap or clamp

## Operation
- **Synchronisers:** inc, dec and inc2 each pass through a SYNC_STAGES-deep flop chain, cleared by rst. Sync-chain outputs are s_inc, s_dec and s_inc2; the FSM uses only these.
- **States:** RESET, IDLE, INC, INC2, DEC, one-hot encoded. Any unreachable encoding goes to RESET on the next edge.
- **rst=1:** state=RESET, count=0, incf=0, decf=0, zf=1, ovf=0, sync chains cleared. rst overrides load.
- **RESET:** goes to IDLE on the next edge.
- **IDLE:** select by priority s_inc > s_dec > s_inc2. Enter INC, DEC or INC2 respectively; count is unchanged on this transition edge. With none active, stay in IDLE.
- **INC, INC2, DEC:** the mode is locked; the other two mode inputs are ignored.
  - If the owning input is still high, apply the step (+1, +STEP2 or -1) and set incf=1 (INC/INC2) or decf=1 (DEC).
  - If it is low, return to IDLE and clear the flag.
- **load=1 in any state other than RESET:**
  - count <= load_val, state <= IDLE;
  - incf=0, decf=0, ovf=0;
  - load takes priority over stepping.
- **Wrap (SATURATE=0):**
  - result = (count ± step) mod 2^WIDTH;
  - ovf=1 when the true result is > 2^WIDTH-1 or < 0.
- **Saturate (SATURATE=1):**
  - result is clamped to 2^WIDTH-1 (up) or 0 (down);
  - ovf=1 on any step that clamps, including a step taken while already at the limit.
- **Flags:**
  - zf = (next count == 0), registered together with count.
  - ovf is high for exactly the cycle after the offending edge; otherwise 0.

## Timing
- Raw input first captured at edge E0, then:
  - s_x is valid after edge E0+SYNC_STAGES-1;
  - the FSM enters the mode at edge E0+SYNC_STAGES;
  - the first count change happens at edge E0+SYNC_STAGES+1.
- If s_x is high for N consecutive edges starting in IDLE, the counter takes N-1 steps.
- Return to IDLE occurs one edge after s_x falls. Re-entry into a new mode needs at least one further edge.
- load: count equals load_val one edge after load is sampled high.
- rst: all outputs take their reset values one edge after rst is sampled high. The first mode entry is possible no earlier than the second edge after rst falls, because RESET→IDLE consumes one edge.
- count, zf, incf, decf and ovf all update on the same edge; no combinational output paths.

## Test plan
- **Reset:** rst high 3 cycles, then low → count=0, zf=1, incf=decf=ovf=0; state reaches IDLE after 1 edge.
- **Basic count, priority and latency:** SYNC_STAGES=2, WIDTH=16. Hold inc high 10 cycles, then low. Assert dec during the hold.
  - count=9, incf high for 9 cycles, dec ignored;
  - first change exactly 3 edges after the first capture.
- **Wrap and zf:** SATURATE=0. load 16'hFFFE, then hold inc2 (STEP2=2) for 2 s_inc2 edges → count=0, zf=1, ovf pulses 1 cycle. Then hold dec for 2 edges → count=16'hFFFF, ovf pulses.
- **Saturate:** SATURATE=1. load 16'h0001, hold dec 4 s_dec edges → count=0 after the first step. ovf pulses on each of the 2 clamped steps; zf stays 1.
- **Load during counting:** load=1 with load_val=16'h1234 while in INC with inc high → count=16'h1234, incf=0, state=IDLE. The next step happens only after IDLE→INC re-entry.
- **Reset mid-operation:** rst=1 while in DEC with count=16'h0050 and load=1 → count=0, zf=1, decf=0; load is ignored.
